// File: rtl/micro_sequencer.sv
// Micro-sequencer for the ucpu datapath: fetches micro-instructions and
// drives the register file DECODE/EXECUTE1/EXECUTE2 protocol.
module micro_sequencer #(
  parameter int MINST_WIDTH = 24,
  parameter int UPC_WIDTH   = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic                   start,
  output logic [UPC_WIDTH-1:0]   minst_addr,
  input  logic [MINST_WIDTH-1:0] minst_data,
  output logic [1:0]             control_state,
  output logic                   reg_file_en,
  output logic                   reg_file_rw,
  output logic [ADDR_WIDTH-1:0]  reg_sel,
  output logic [DATA_WIDTH-1:0]  reg_wr_data,
  input  logic [DATA_WIDTH-1:0]  reg_rd_data,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic                   halted
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EX1, EX2, WB, HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_LDI, OP_LD, OP_ST,
    OP_ADD, OP_BZ, OP_JMP, OP_HALT
  } op_t;

  state_t               state;
  op_t                  ir_op;
  logic [UPC_WIDTH-1:0] upc;

  op_t                   op;
  logic [3:0]            rsel;
  logic [UPC_WIDTH-1:0]  tgt;
  logic [DATA_WIDTH-1:0] imm;
  logic [UPC_WIDTH-1:0]  upc_inc;
  logic                  unused_bits;

  assign op          = op_t'(minst_data[23:21]);
  assign rsel        = minst_data[20:17];
  assign tgt         = minst_data[UPC_WIDTH-1:0];
  assign imm         = minst_data[DATA_WIDTH-1:0];
  assign unused_bits = ^minst_data[16:10];
  assign upc_inc     = upc + UPC_WIDTH'(1);
  assign minst_addr  = upc;

  // Bus outputs are rebuilt every cycle from next-state decisions,
  // so they are registered and drop to zero outside EX1/EX2.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state         <= FETCH;
      ir_op         <= OP_NOP;
      upc           <= '0;
      acc           <= '0;
      halted        <= 1'b0;
      control_state <= 2'd0;
      reg_file_en   <= 1'b0;
      reg_file_rw   <= 1'b0;
      reg_sel       <= '0;
      reg_wr_data   <= '0;
    end else begin
      control_state <= 2'd0;
      reg_file_en   <= 1'b0;
      reg_file_rw   <= 1'b0;
      reg_sel       <= '0;
      reg_wr_data   <= '0;
      unique case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir_op <= op;
          unique case (op)
            OP_NOP: begin
              upc   <= upc_inc;
              state <= FETCH;
            end
            OP_LDI: begin
              acc   <= imm;
              upc   <= upc_inc;
              state <= FETCH;
            end
            OP_BZ: begin
              upc   <= (acc == '0) ? tgt : upc_inc;
              state <= FETCH;
            end
            OP_JMP: begin
              upc   <= tgt;
              state <= FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALTED;
            end
            OP_LD, OP_ST, OP_ADD: begin
              control_state <= 2'd1;
              reg_file_en   <= 1'b1;
              reg_file_rw   <= (op == OP_ST);
              reg_sel       <= ADDR_WIDTH'(rsel);
              reg_wr_data   <= acc;
              state         <= EX1;
            end
          endcase
        end
        EX1: begin
          control_state <= 2'd2;
          reg_file_en   <= 1'b1;
          reg_file_rw   <= reg_file_rw;
          reg_sel       <= reg_sel;
          reg_wr_data   <= reg_wr_data;
          state         <= EX2;
        end
        EX2: begin
          if (ir_op == OP_ST) begin
            upc   <= upc_inc;
            state <= FETCH;
          end else begin
            control_state <= 2'd3;
            state         <= WB;
          end
        end
        WB: begin
          acc   <= (ir_op == OP_LD) ? reg_rd_data : acc + reg_rd_data;
          upc   <= upc_inc;
          state <= FETCH;
        end
        HALTED: begin
          if (start) begin
            upc    <= '0;
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with micro-ROM and
// register-file models.
module tb_micro_sequencer;

  logic        clk;
  logic        sys_reset;
  logic        start;
  logic [9:0]  minst_addr;
  logic [23:0] minst_data;
  logic [1:0]  control_state;
  logic        reg_file_en;
  logic        reg_file_rw;
  logic [4:0]  reg_sel;
  logic [7:0]  reg_wr_data;
  logic [7:0]  reg_rd_data;
  logic [7:0]  acc;
  logic        halted;

  int total = 0;
  int bad = 0;

  logic [23:0] rom [0:1023];
  logic [7:0]  regs [0:31];

  micro_sequencer dut (
    .sys_clk      (clk),
    .sys_reset    (sys_reset),
    .start        (start),
    .minst_addr   (minst_addr),
    .minst_data   (minst_data),
    .control_state(control_state),
    .reg_file_en  (reg_file_en),
    .reg_file_rw  (reg_file_rw),
    .reg_sel      (reg_sel),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_data  (reg_rd_data),
    .acc          (acc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) minst_data <= rom[minst_addr];

  always @(posedge clk) begin
    if (reg_file_en && reg_file_rw) regs[reg_sel] <= reg_wr_data;
    if (reg_file_en && !reg_file_rw) reg_rd_data <= regs[reg_sel];
  end

  function automatic logic [23:0] mi(input logic [2:0] op,
                                     input logic [3:0] rs,
                                     input logic [9:0] t);
    return {op, rs, 7'd0, t};
  endfunction

  task automatic hold_reset();
    sys_reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 24'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    sys_reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    rom[0] = mi(3'd1, 4'd0, 10'h05A);
    rom[1] = mi(3'd3, 4'd3, 10'h000);
    #1;
    total++;
    if ({control_state, reg_file_en, reg_file_rw, reg_sel, reg_wr_data,
         acc, halted, minst_addr} !== 29'd0) begin
      bad++;
      $display("FAIL reset_state outs=%h want 0",
               {control_state, reg_file_en, reg_file_rw, reg_sel,
                reg_wr_data, acc, halted, minst_addr});
    end
    release_reset();
    step(4);
    total++;
    if (reg_file_en !== 1'b1 || control_state !== 2'd1) begin
      bad++;
      $display("FAIL reset_pre_ex1 en=%b cs=%0d want 1/1",
               reg_file_en, control_state);
    end
    @(posedge clk);
    #2;
    sys_reset = 1'b0;
    #1;
    total++;
    if ({control_state, reg_file_en, reg_file_rw, reg_sel, reg_wr_data,
         acc, halted, minst_addr} !== 29'd0) begin
      bad++;
      $display("FAIL reset_async outs=%h want 0",
               {control_state, reg_file_en, reg_file_rw, reg_sel,
                reg_wr_data, acc, halted, minst_addr});
    end
    release_reset();
    step(1);
    total++;
    if (minst_addr !== 10'd0 || control_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_fetch addr=%h cs=%0d want 0/0",
               minst_addr, control_state);
    end
    step(1);
    total++;
    if (acc !== 8'h5A || minst_addr !== 10'd1) begin
      bad++;
      $display("FAIL reset_first_ldi acc=%h addr=%h want 5a/001",
               acc, minst_addr);
    end
  endtask

  task automatic test_ldi_st_ld();
    logic [1:0] exp_cs [1:11];
    logic       exp_en [1:11];
    logic       exp_rw [1:11];
    int         wr_cycles;
    exp_cs = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0,
               2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wr_cycles = 0;
    hold_reset();
    rom[0] = mi(3'd1, 4'd0, 10'h05A);
    rom[1] = mi(3'd3, 4'd3, 10'h000);
    rom[2] = mi(3'd2, 4'd3, 10'h000);
    rom[3] = mi(3'd1, 4'd0, 10'h000);
    rom[4] = mi(3'd2, 4'd3, 10'h000);
    release_reset();
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (reg_file_en && reg_file_rw) wr_cycles++;
      total++;
      if (control_state !== exp_cs[k] || reg_file_en !== exp_en[k] ||
          reg_file_rw !== exp_rw[k]) begin
        bad++;
        $display("FAIL seq_cycle%0d cs=%0d en=%b rw=%b want %0d/%b/%b",
                 k, control_state, reg_file_en, reg_file_rw,
                 exp_cs[k], exp_en[k], exp_rw[k]);
      end
      if (k == 4) begin
        total++;
        if (reg_sel !== 5'd3 || reg_wr_data !== 8'h5A) begin
          bad++;
          $display("FAIL st_bus sel=%0d wd=%h want 3/5a",
                   reg_sel, reg_wr_data);
        end
      end
      if (k == 10) begin
        total++;
        if (minst_addr !== 10'd2 || reg_sel !== 5'd0) begin
          bad++;
          $display("FAIL ld_wb addr=%h sel=%0d want 002/0",
                   minst_addr, reg_sel);
        end
      end
    end
    total++;
    if (wr_cycles !== 2) begin
      bad++;
      $display("FAIL st_en_cycles got=%0d want 2", wr_cycles);
    end
    total++;
    if (minst_addr !== 10'd3 || acc !== 8'h5A || regs[3] !== 8'h5A) begin
      bad++;
      $display("FAIL seq_end addr=%h acc=%h r3=%h want 003/5a/5a",
               minst_addr, acc, regs[3]);
    end
    step(2);
    total++;
    if (acc !== 8'h00) begin
      bad++;
      $display("FAIL ldi_zero acc=%h want 00", acc);
    end
    step(5);
    total++;
    if (acc !== 8'h5A || minst_addr !== 10'd5) begin
      bad++;
      $display("FAIL ld_r3 acc=%h addr=%h want 5a/005", acc, minst_addr);
    end
  endtask

  task automatic test_add_wrap();
    hold_reset();
    rom[0] = mi(3'd1, 4'd0, 10'h020);
    rom[1] = mi(3'd3, 4'd2, 10'h000);
    rom[2] = mi(3'd1, 4'd0, 10'h0F0);
    rom[3] = mi(3'd4, 4'd2, 10'h000);
    release_reset();
    step(12);
    total++;
    if (minst_addr !== 10'd3 || acc !== 8'hF0) begin
      bad++;
      $display("FAIL add_pre addr=%h acc=%h want 003/f0", minst_addr, acc);
    end
    step(1);
    total++;
    if (acc !== 8'h10 || minst_addr !== 10'd4) begin
      bad++;
      $display("FAIL add_wrap acc=%h addr=%h want 10/004", acc, minst_addr);
    end
  endtask

  task automatic test_bz();
    hold_reset();
    rom[0]     = mi(3'd1, 4'd0, 10'h000);
    rom[1]     = mi(3'd5, 4'd0, 10'h100);
    rom[10'h100] = mi(3'd1, 4'd0, 10'h001);
    rom[10'h101] = mi(3'd5, 4'd0, 10'h200);
    release_reset();
    step(4);
    total++;
    if (minst_addr !== 10'h100) begin
      bad++;
      $display("FAIL bz_taken addr=%h want 100", minst_addr);
    end
    step(4);
    total++;
    if (minst_addr !== 10'h102 || acc !== 8'h01) begin
      bad++;
      $display("FAIL bz_not_taken addr=%h acc=%h want 102/01",
               minst_addr, acc);
    end
  endtask

  task automatic test_wrap();
    hold_reset();
    rom[0]       = mi(3'd6, 4'd9, 10'h3FF);
    rom[10'h3FF] = mi(3'd0, 4'd0, 10'h000);
    release_reset();
    step(2);
    total++;
    if (minst_addr !== 10'h3FF) begin
      bad++;
      $display("FAIL jmp addr=%h want 3ff", minst_addr);
    end
    step(2);
    total++;
    if (minst_addr !== 10'h000) begin
      bad++;
      $display("FAIL upc_wrap addr=%h want 000", minst_addr);
    end
  endtask

  task automatic test_halt();
    hold_reset();
    rom[0] = mi(3'd1, 4'd0, 10'h077);
    rom[5] = mi(3'd7, 4'd0, 10'h000);
    release_reset();
    step(11);
    start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (halted !== 1'b1 || minst_addr !== 10'd5) begin
      bad++;
      $display("FAIL halt_enter halted=%b addr=%h want 1/005",
               halted, minst_addr);
    end
    step(3);
    total++;
    if (halted !== 1'b1 || minst_addr !== 10'd5 || control_state !== 2'd0) begin
      bad++;
      $display("FAIL halt_hold halted=%b addr=%h cs=%0d want 1/005/0",
               halted, minst_addr, control_state);
    end
    rom[0] = mi(3'd0, 4'd0, 10'h000);
    start = 1'b1;
    step(1);
    start = 1'b0;
    total++;
    if (halted !== 1'b0 || minst_addr !== 10'd0 || acc !== 8'h77) begin
      bad++;
      $display("FAIL restart halted=%b addr=%h acc=%h want 0/000/77",
               halted, minst_addr, acc);
    end
    step(2);
    total++;
    if (minst_addr !== 10'd1 || acc !== 8'h77) begin
      bad++;
      $display("FAIL restart_run addr=%h acc=%h want 001/77",
               minst_addr, acc);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_st_ld();
    test_add_wrap();
    test_bz();
    test_wrap();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Micro-sequencer for the ucpu datapath: the initiator side of the micro register file's DECODE/EXECUTE1/EXECUTE2 protocol. It fetches 24-bit micro-instructions from a synchronous micro-ROM and keeps a 10-bit micro-PC and an 8-bit accumulator. For register operations it drives reg_file_en/reg_file_rw/reg_sel/reg_wr_data/control_state with the cycle timing the register file expects, and captures reg_rd_data on the return path.

## Interface
- MINST_WIDTH, 24, micro-instruction width
- UPC_WIDTH, 10, micro-PC / branch-target width
- DATA_WIDTH, 8, accumulator and register-file data width
- ADDR_WIDTH, 5, register-file select width
- sys_clk  input  1  single clock, all state on rising edge
- sys_reset  input  1  asynchronous, active-low reset
- start  input  1  restart pulse; honoured only while halted=1
- minst_addr  output  UPC_WIDTH  micro-ROM address (= micro-PC register)
- minst_data  input  MINST_WIDTH  micro-ROM data, valid one cycle after minst_addr
- control_state  output  2  0=DECODE/idle, 1=EXECUTE1, 2=EXECUTE2, 3=WRITEBACK
- reg_file_en  output  1  register-file enable
- reg_file_rw  output  1  0=read, 1=write
- reg_sel  output  ADDR_WIDTH  register select, zero-extended from the 4-bit field
- reg_wr_data  output  DATA_WIDTH  write data (accumulator)
- reg_rd_data  input  DATA_WIDTH  registered read data from the register file
- acc  output  DATA_WIDTH  accumulator
- halted  output  1  sequencer stopped on HALT

## Operation
- Instruction fields: op=[23:21], rsel=[20:17], [16:10] ignored, tgt=[9:0], imm=[7:0].
- Opcodes:
  - 0 NOP
  - 1 LDI: acc<=imm
  - 2 LD: acc<=R[rsel]
  - 3 ST: R[rsel]<=acc
  - 4 ADD: acc<=acc+R[rsel], mod 256, carry discarded
  - 5 BZ: upc<=tgt if acc==0, else upc+1
  - 6 JMP: upc<=tgt
  - 7 HALT
- Internal states: FETCH, DECODE, EX1, EX2, WB, HALTED.
- FETCH: ROM samples minst_addr at the end of this cycle. Next state is DECODE.
- DECODE: minst_data is latched into the instruction register.
  - NOP/LDI/BZ/JMP: execute here, update upc, go to FETCH.
  - HALT: upc unchanged; go to HALTED.
  - ST/LD/ADD: go to EX1.
- EX1, EX2: reg_file_en=1 in both cycles. reg_file_rw=1 for ST, else 0. reg_sel=rsel, reg_wr_data=acc, all held constant across both cycles.
  - ST: after EX2, upc<=upc+1, go to FETCH.
  - LD/ADD: go to WB.
- WB: reg_rd_data is valid in this cycle. LD/ADD update acc, upc<=upc+1, go to FETCH.
- Outside EX1/EX2: reg_file_en=0, reg_file_rw=0, reg_sel=0, reg_wr_data=0.
- control_state outputs:
  - 0 in FETCH/DECODE/HALTED
  - 1 in EX1, 2 in EX2
  - 3 in WB; the register file ignores this value.
- HALTED: holds until start=1, then upc<=0, acc unchanged, go to FETCH.
- start is ignored in every other state, including the DECODE cycle of a HALT.
- upc+1 wraps 1023→0.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.

## Timing
- Reset (sys_reset=0, asynchronous):
  - state=FETCH, upc=0, acc=0, halted=0
  - control_state=0, reg_file_en=0, reg_file_rw=0, reg_sel=0, reg_wr_data=0
  - Takes effect immediately, including mid-EX1/EX2; register-file enable drops without waiting for a clock.
- After reset release, the first rising edge is FETCH of address 0.
- Cycles per instruction:
  - NOP/LDI/BZ/JMP: 2
  - HALT: 2 to reach halted=1
  - ST: 4
  - LD/ADD: 5
- halted rises on the edge ending HALT's DECODE and falls on the edge after start is sampled high.
- BZ uses the acc value present during DECODE, so it sees any acc update from the preceding instruction.

## Test plan
- Reset:
  - Stimulus: assert sys_reset=0 mid-run, then release.
  - Required: all outputs 0 immediately on assertion; minst_addr=0; first FETCH on the first edge after release.
- LDI 0x5A; ST r3; LD r3 (bench register-file model):
  - Required: reg_file_en high exactly 2 cycles for ST with rw=1, sel=3, wr_data=0x5A.
  - Required: LD shows control_state sequence 1,2,3; acc=0x5A after WB.
  - Required: 11 cycles total from the first FETCH.
- ADD wrap:
  - Stimulus: R2=0x20, acc=0xF0, ADD r2.
  - Required: acc=0x10; upc advances by 1.
- BZ:
  - Stimulus: acc=0 with BZ tgt=0x100.
  - Required: minst_addr=0x100. With acc=0x01, minst_addr=previous upc+1.
- Wrap:
  - Stimulus: JMP 0x3FF, NOP at 0x3FF.
  - Required: minst_addr=0x000 next.
- HALT/start:
  - Stimulus: HALT at 5; start pulsed while halted; start pulsed during the HALT DECODE cycle.
  - Required: halted=1, minst_addr stays 5 until start, then fetch restarts from 0 with acc preserved.
  - Required: a start pulse during the HALT DECODE cycle is ignored.
